demod_qarctan: RTL and testbench



---
 rtl/demod_qarctan_if.sv | 37 +++
 rtl/demod_qarctan.sv | 183 ++++++++++++++++++
 tb/tb_demod_qarctan.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demod_qarctan_if.sv
// demod_qarctan bus bundle: input FIFO, divider and output FIFO lines.
// master is the demodulator side, slave is the parent/environment side.
interface demod_qarctan_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] real_in;
  logic signed [DATA_WIDTH-1:0] imag_in;
  logic                         in_empty;
  logic                         in_rd_en;
  logic                         div_start;
  logic signed [DATA_WIDTH-1:0] div_numerator;
  logic signed [DATA_WIDTH-1:0] div_denominator;
  logic signed [DATA_WIDTH-1:0] div_quotient;
  logic                         div_done;
  logic                         div_error;
  logic signed [DATA_WIDTH-1:0] demod_out;
  logic                         out_full;
  logic                         out_wr_en;

  modport master (
    input  real_in, imag_in, in_empty,
    input  div_quotient, div_done, div_error,
    input  out_full,
    output in_rd_en, div_start,
    output div_numerator, div_denominator,
    output demod_out, out_wr_en
  );

  modport slave (
    output real_in, imag_in, in_empty,
    output div_quotient, div_done, div_error,
    output out_full,
    input  in_rd_en, div_start,
    input  div_numerator, div_denominator,
    input  demod_out, out_wr_en
  );
endinterface

// File: rtl/demod_qarctan.sv
// FM quadrature demodulator: conjugate product, qarctan via an external
// divider, gain, one output sample per input sample.
module demod_qarctan #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412,
  parameter int GAIN       = 758
) (
  input logic             clock,
  input logic             reset,
  demod_qarctan_if.master bus
);
  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  typedef logic signed [W-1:0]  word_t;
  typedef logic signed [W2-1:0] wide_t;

  localparam word_t Q1 = word_t'(QUAD1);
  localparam word_t Q3 = word_t'(QUAD3);
  localparam word_t GN = word_t'(GAIN);

  typedef enum logic [2:0] {
    S_READ,
    S_MULT,
    S_DIV,
    S_START,
    S_WAIT,
    S_ANGLE,
    S_GAIN,
    S_WRITE
  } state_t;

  state_t state;
  state_t state_n;

  word_t prev_r;
  word_t prev_i;
  word_t cur_r;
  word_t cur_i;
  word_t r;
  word_t i;
  word_t quo;
  word_t angle;
  word_t out_reg;
  word_t num_q;
  word_t den_q;

  word_t r_n;
  word_t i_n;
  word_t abs_y;
  word_t num_n;
  word_t den_n;
  word_t base;
  word_t a;
  word_t angle_n;
  word_t gain_n;

  logic rd_en;
  logic wr_en;

  // Arithmetic shift down by the fraction bits, floor, back to word width.
  function automatic word_t deq(input wide_t p);
    return word_t'(p >>> BITS);
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_READ;
    end else begin
      state <= state_n;
    end
  end

  // Next state and FIFO strobes.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      S_READ: begin
        if (!bus.in_empty) begin
          rd_en   = 1'b1;
          state_n = S_MULT;
        end
      end
      S_MULT:  state_n = S_DIV;
      S_DIV:   state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (bus.div_done) begin
          state_n = S_ANGLE;
        end
      end
      S_ANGLE: state_n = S_GAIN;
      S_GAIN:  state_n = S_WRITE;
      S_WRITE: begin
        if (!bus.out_full) begin
          wr_en   = 1'b1;
          state_n = S_READ;
        end
      end
      default: state_n = S_READ;
    endcase
  end

  // Conjugate product, divider operands, angle and gain.
  always_comb begin
    r_n = deq(wide_t'(prev_r) * wide_t'(cur_r))
        + deq(wide_t'(prev_i) * wide_t'(cur_i));
    i_n = deq(wide_t'(prev_r) * wide_t'(cur_i))
        - deq(wide_t'(prev_i) * wide_t'(cur_r));

    abs_y = (i[W-1] ? -i : i) + word_t'(1);
    if (!r[W-1]) begin
      num_n = (r - abs_y) << BITS;
      den_n = r + abs_y;
    end else begin
      num_n = (r + abs_y) << BITS;
      den_n = abs_y - r;
    end

    base    = r[W-1] ? Q3 : Q1;
    a       = base - deq(wide_t'(Q1) * wide_t'(quo));
    angle_n = i[W-1] ? -a : a;

    gain_n = deq(wide_t'(GN) * wide_t'(angle));
  end

  // Datapath registers, each loaded in its own state.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_r  <= '0;
      prev_i  <= '0;
      cur_r   <= '0;
      cur_i   <= '0;
      r       <= '0;
      i       <= '0;
      quo     <= '0;
      angle   <= '0;
      out_reg <= '0;
      num_q   <= '0;
      den_q   <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (!bus.in_empty) begin
            cur_r <= bus.real_in;
            cur_i <= bus.imag_in;
          end
        end
        S_MULT: begin
          r      <= r_n;
          i      <= i_n;
          prev_r <= cur_r;
          prev_i <= cur_i;
        end
        S_DIV: begin
          num_q <= num_n;
          den_q <= den_n;
        end
        S_WAIT: begin
          if (bus.div_done) begin
            quo <= bus.div_error ? '0 : bus.div_quotient;
          end
        end
        S_ANGLE: angle <= angle_n;
        S_GAIN:  out_reg <= gain_n;
        default: ;
      endcase
    end
  end

  assign bus.in_rd_en        = rd_en;
  assign bus.out_wr_en       = wr_en;
  assign bus.div_start       = (state == S_START);
  assign bus.div_numerator   = num_q;
  assign bus.div_denominator = den_q;
  assign bus.demod_out       = out_reg;

endmodule

// File: tb/tb_demod_qarctan.sv
// Bench for demod_qarctan: FIFO and divider models around the DUT,
// scoreboard of expected outputs, directed steps in one sequence.
module tb_demod_qarctan;
  logic clock;
  logic reset;

  demod_qarctan_if #(.DATA_WIDTH(32)) bus ();

  demod_qarctan dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int r;
    int i;
  } samp_t;

  samp_t in_q[$];
  int    exp_q[$];

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int pushes   = 0;
  int starts   = 0;
  int m_pr     = 0;
  int m_pi     = 0;
  int lat_fixed = 0;

  int   busy = 0;
  int   cnt  = 0;
  logic last_start = 1'b0;
  logic signed [31:0] snap_n;
  logic signed [31:0] snap_d;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(int pr, int pi, int cr, int ci);
    longint rr, ii, ay, num, den, q, a, ang;
    rr = ((longint'(pr) * cr) >>> 10) + ((longint'(pi) * ci) >>> 10);
    ii = ((longint'(pr) * ci) >>> 10) - ((longint'(pi) * cr) >>> 10);
    ay = (ii < 0 ? -ii : ii) + 1;
    if (rr >= 0) begin
      num = (rr - ay) * 1024;
      den = rr + ay;
    end else begin
      num = (rr + ay) * 1024;
      den = ay - rr;
    end
    q   = num / den;
    a   = (rr >= 0 ? 804 : 2412) - ((804 * q) >>> 10);
    ang = (ii < 0) ? -a : a;
    return int'((758 * ang) >>> 10);
  endfunction

  task automatic fifo_sync();
    bus.in_empty = (in_q.size() == 0);
    bus.real_in  = (in_q.size() != 0) ? in_q[0].r : 0;
    bus.imag_in  = (in_q.size() != 0) ? in_q[0].i : 0;
  endtask

  task automatic push_exp(input int r, input int i, input int e);
    samp_t s;
    s.r = r;
    s.i = i;
    in_q.push_back(s);
    exp_q.push_back(e);
    m_pr = r;
    m_pi = i;
    fifo_sync();
  endtask

  task automatic push_model(input int r, input int i);
    push_exp(r, i, model(m_pr, m_pi, r, i));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++)
      @(posedge clock);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"}, bus.in_rd_en, 0);
    chk({tag, "_start"}, bus.div_start, 0);
    chk({tag, "_num"}, bus.div_numerator, 0);
    chk({tag, "_den"}, bus.div_denominator, 0);
    chk({tag, "_out"}, bus.demod_out, 0);
    chk({tag, "_wr"}, bus.out_wr_en, 0);
  endtask

  // Input FIFO: pop the head after each accepted read.
  always @(posedge clock) begin
    if (bus.in_rd_en) begin
      #1;
      if (in_q.size() != 0) void'(in_q.pop_front());
      pops++;
      fifo_sync();
    end
  end

  // Divider model: fixed or random latency, quotient from live operands.
  always @(negedge clock) begin
    if (reset) begin
      busy = 0;
      bus.div_done = 1'b0;
      bus.div_error = 1'b0;
      bus.div_quotient = 0;
      last_start = 1'b0;
    end else begin
      bus.div_done = 1'b0;
      bus.div_error = 1'b0;
      if (busy != 0) begin
        cnt--;
        if (cnt == 0) begin
          busy = 0;
          chk("op_num_stable", bus.div_numerator, snap_n);
          chk("op_den_stable", bus.div_denominator, snap_d);
          bus.div_done = 1'b1;
          if (bus.div_denominator == 0) begin
            bus.div_error = 1'b1;
            bus.div_quotient = 0;
          end else begin
            bus.div_quotient = bus.div_numerator / bus.div_denominator;
          end
        end
      end
      if (bus.div_start) begin
        starts++;
        chk("start_width", last_start, 0);
        busy = 1;
        cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
        snap_n = bus.div_numerator;
        snap_d = bus.div_denominator;
      end
      last_start = bus.div_start;
    end
  end

  // Output FIFO monitor: pop the scoreboard on every push.
  always @(negedge clock) begin
    if (!reset && bus.out_wr_en) begin
      pushes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_push", 1, 0);
      end else begin
        chk("demod_out", bus.demod_out, exp_q.pop_front());
      end
    end
    if (!reset && bus.in_rd_en) begin
      chk("rd_when_empty", bus.in_empty, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, s0, hv;
    logic got;
    reset = 1'b1;
    bus.out_full = 1'b0;
    fifo_sync();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    push_exp(1024, 0, 1190);
    wait_drain("first", 100);
    push_exp(1024, 0, 1);
    wait_drain("second", 100);
    push_exp(0, 1024, 1190);
    push_model(1024, 0);
    push_exp(0, -1024, -1191);
    push_model(1024, 0);
    push_exp(-1024, 0, 2379);
    wait_drain("quads", 200);

    for (int k = 0; k < 6; k++) begin
      push_model(int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 4000)) - 2000);
    end
    wait_drain("random", 300);

    @(posedge clock); #1;
    bus.out_full = 1'b1;
    push_model(1024, 0);
    push_model(700, -300);
    repeat (30) @(posedge clock);
    #1;
    p0 = pops;
    w0 = pushes;
    hv = exp_q[0];
    repeat (20) @(posedge clock);
    #1;
    chk("full_no_push", pushes, w0);
    chk("full_no_pop", pops, p0);
    chk("full_out_hold", bus.demod_out, hv);
    bus.out_full = 1'b0;
    @(posedge clock); #1;
    chk("release_push", pushes, w0 + 1);
    @(posedge clock);
    @(negedge clock);
    chk("release_pop", pops, p0 + 1);
    chk("release_single", pushes, w0 + 1);
    wait_drain("release_drain", 100);

    @(posedge clock); #1;
    p0 = pops;
    s0 = starts;
    repeat (20) @(posedge clock);
    #1;
    chk("empty_no_pop", pops, p0);
    chk("empty_no_start", starts, s0);

    lat_fixed = 12;
    push_model(500, 300);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got = bus.div_start;
    end
    chk("start_seen", got, 1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_zero("mid_reset");
    exp_q.delete();
    m_pr = 0;
    m_pi = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    lat_fixed = 0;
    push_exp(1024, 0, 1190);
    wait_drain("after_reset", 100);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
